// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor
// Multi-word unsigned subtractor that works through the operands one 4-bit
// nibble per clock, least significant nibble first. The borrow between
// nibbles is registered. Each 4-bit slice is built from the same 1-bit
// full-subtractor equations as the ripple subtractor slice.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The producer holds its payload stable while valid is high.
// The consumer may raise ready at any time. in_ready and out_valid are
// decoded from registered state only, so neither has a combinational path
// from any input.
module nibble_serial_subtractor #(
    parameter int NIBBLES = 4               // legal range 1..16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   bin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   diff,
    output logic                   bout,
    output logic                   busy,
    output logic [1:0]             state_dbg
);

    localparam int W  = 4 * NIBBLES;
    // The index register needs at least one bit, including when NIBBLES == 1.
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    diff_reg;
    logic            bout_reg;
    logic            borrow;
    logic [IW-1:0]   idx;

    logic            accept;
    logic            last_nibble;
    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [3:0]      nib_d;
    logic            nib_bo;
    logic [W-1:0]    diff_next;

    // 4-bit ripple of 1-bit full subtractors. The result is {borrow_out, difference}.
    function automatic logic [4:0] sub_nibble(input logic [3:0] x,
                                              input logic [3:0] y,
                                              input logic       bi);
        logic [3:0] d;
        logic       br;
        d  = 4'd0;
        br = bi;
        for (int i = 0; i < 4; i++) begin
            d[i] = x[i] ^ y[i] ^ br;
            br   = (~x[i] & (y[i] ^ br)) | (y[i] & br);
        end
        return {br, d};
    endfunction

    assign accept      = (state == IDLE) && in_valid;
    assign last_nibble = (idx == LAST_IDX);

    // Select the current operand nibbles and form the updated diff word.
    always_comb begin
        a_nib     = a_reg[idx*4 +: 4];
        b_nib     = b_reg[idx*4 +: 4];
        {nib_bo, nib_d} = sub_nibble(a_nib, b_nib, borrow);
        diff_next = diff_reg;
        diff_next[idx*4 +: 4] = nib_d;
    end

    // State register. An asynchronous reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and outputs decoded from the registered state.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_nibble) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one nibble per RUN cycle. The result
    // registers hold their value through DONE and IDLE until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            diff_reg <= '0;
            bout_reg <= 1'b0;
            borrow   <= 1'b0;
            idx      <= '0;
        end else if (accept) begin
            a_reg    <= a;
            b_reg    <= b;
            diff_reg <= '0;
            borrow   <= bin;
            idx      <= '0;
        end else if (state == RUN) begin
            diff_reg <= diff_next;
            borrow   <= nib_bo;
            if (last_nibble) begin
                bout_reg <= nib_bo;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    assign diff      = diff_reg;
    assign bout      = bout_reg;
    assign state_dbg = state;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor with NIBBLES = 4.
module tb_nibble_serial_subtractor;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          bin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  diff;
    logic          bout;
    logic          busy;
    logic [1:0]    state_dbg;

    int tests = 0;
    int fails = 0;

    nibble_serial_subtractor #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Clock and reset defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present operands at a negedge, let the next posedge accept them, then drop in_valid.
    task automatic accept_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        a        = av;
        b        = bv;
        bin      = bi;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid, bounded.
    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, N);
    endtask

    // Hand the result to the consumer and confirm the return to IDLE.
    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_ov_low"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic bi, input logic [W-1:0] exp_d, input logic exp_b);
        accept_op(av, bv, bi);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(tag);
        chk({tag, "_diff"}, {16'd0, diff}, {16'd0, exp_d});
        chk({tag, "_bout"}, {31'd0, bout}, {31'd0, exp_b});
        release_out(tag);
    endtask

    initial begin
        bit saw_ov;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_diff", {16'd0, diff}, 32'h0000);
        chk("rst_bout", {31'd0, bout}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Basic subtract
        run_op("basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0);

        // Cross-nibble borrow ripple, observed nibble by nibble
        accept_op(16'h1000, 16'h0001, 1'b0);
        chk("rip_diff0", {16'd0, diff}, 32'h0000);
        @(posedge clk); @(negedge clk);
        chk("rip_n0", {16'd0, diff}, 32'h000F);
        @(posedge clk); @(negedge clk);
        chk("rip_n1", {16'd0, diff}, 32'h00FF);
        @(posedge clk); @(negedge clk);
        chk("rip_n2", {16'd0, diff}, 32'h0FFF);
        chk("rip_ov_early", {31'd0, out_valid}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("rip_n3", {16'd0, diff}, 32'h0FFF);
        chk("rip_ov", {31'd0, out_valid}, 32'd1);
        chk("rip_bout", {31'd0, bout}, 32'd0);
        release_out("rip");

        // Underflow and borrow-in
        run_op("uflow", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
        run_op("ffff_bin", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        run_op("8000_bin", 16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0);

        // Backpressure with new operands offered during DONE
        accept_op(16'h5678, 16'h1234, 1'b0);
        wait_done("bp");
        chk("bp_diff", {16'd0, diff}, 32'h4444);
        a        = 16'hAAAA;
        b        = 16'h1111;
        bin      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            chk("bp_hold_diff", {16'd0, diff}, 32'h4444);
            chk("bp_hold_bout", {31'd0, bout}, 32'd0);
            chk("bp_hold_ov", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle_ov", {31'd0, out_valid}, 32'd0);
        chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_idle_diff", {16'd0, diff}, 32'h4444);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("bp_accepted", {31'd0, busy}, 32'd1);
        wait_done("bp2");
        chk("bp2_diff", {16'd0, diff}, 32'h9999);
        chk("bp2_bout", {31'd0, bout}, 32'd0);
        release_out("bp2");

        // Reset during RUN with idx = 2
        accept_op(16'h1234, 16'h0001, 1'b0);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("mid_diff", {16'd0, diff}, 32'h0033);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_ov", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_diff", {16'd0, diff}, 32'h0000);
        chk("mid_rst_bout", {31'd0, bout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_ov = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid) saw_ov = 1'b1;
        end
        chk("mid_no_ov", {31'd0, saw_ov}, 32'd0);
        run_op("fresh", 16'h00FF, 16'h0010, 1'b0, 16'h00EF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Sequential multi-word subtractor. It accepts a wide operand pair over a valid/ready handshake and computes one 4-bit nibble per clock, least significant nibble first. Nibble borrow-out is registered and fed back as the next nibble's borrow-in, using the same 1-bit full-subtractor equations as the team's ripple subtractor slice. The block sits upstream of wide-arithmetic consumers, such as the comparator and divider stages. It trades latency for a single 4-bit datapath.

## Interface
- NIBBLES, default 4, number of 4-bit nibbles per operand; W = 4*NIBBLES; legal range 1..16.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high; takes effect immediately, released synchronously by the environment.
- in_valid  input  1  operand pair (a, b, bin) is presented.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  W  minuend, unsigned.
- b  input  W  subtrahend, unsigned.
- bin  input  1  borrow-in to nibble 0.
- out_valid  output  1  result held on diff/bout.
- out_ready  input  1  consumer takes the result.
- diff  output  W  a - b - bin mod 2^W.
- bout  output  1  final borrow; 1 iff a < b + bin (unsigned).
- busy  output  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE
  - in_ready=1.
  - On in_valid at a clock edge: register a and b into A/B, set borrow register to bin, clear the nibble index to 0, clear the diff register, go to RUN.
- RUN, each cycle, for nibble idx:
  - Compute d = A[idx]^B[idx]^borrow, ripple across the 4 bits with per-bit bout = ~a&(b^bin) | b&bin.
  - Write d into diff[4*idx+3:4*idx] and load the nibble borrow-out into the borrow register.
  - If idx == NIBBLES-1, latch bout = nibble borrow-out and go to DONE; otherwise idx+1.
- DONE
  - out_valid=1; diff and bout held stable.
  - On out_ready: go to IDLE, deassert out_valid.
  - diff and bout keep their last value until the next accept.
- No overlap: in_valid in RUN or DONE is ignored (in_ready=0). Operands are sampled only at the accept edge, so a and b may change afterwards.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - diff=0, bout=0, borrow=0, idx=0, A=B=0.
- Reset mid-RUN or mid-DONE: the result is discarded and the block returns to IDLE immediately (asynchronous); no out_valid follows.
- Width: the index counter is ceil(log2(NIBBLES)) bits, minimum 1. It never wraps past NIBBLES-1.

## Timing
- Accept at edge T0 (in_valid & in_ready).
- Nibble k is written at edge T0+1+k.
- out_valid rises after edge T0+NIBBLES: NIBBLES cycles of latency.
- Earliest return to IDLE is T0+NIBBLES+1 (out_ready already high). The earliest next accept is at that following edge.
- Throughput is one operation per NIBBLES+2 cycles at best.
- in_ready and out_valid are decoded from registered state only, with no combinational path from inputs.
- out_ready held low: DONE persists indefinitely and outputs do not change.
- For NIBBLES=1, RUN lasts exactly one cycle.

## Test plan
- Reset then idle, NIBBLES=4.
  - After reset: in_ready=1, out_valid=0, diff=0x0000, bout=0, busy=0.
- Basic subtract: a=0x1234, b=0x0234, bin=0 accepted at T0.
  - out_valid=1 after edge T0+4, with diff=0x1000 and bout=0.
  - out_ready=1 returns the block to IDLE at the next edge.
- Cross-nibble borrow ripple: a=0x1000, b=0x0001, bin=0 -> diff=0x0FFF, bout=0.
  - Nibble writes in order 0xF, 0xF, 0xF, 0x0.
- Underflow and bin: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1.
  - a=0xFFFF, b=0xFFFF, bin=1 -> diff=0xFFFF, bout=1.
  - a=0x8000, b=0x7FFF, bin=1 -> diff=0x0000, bout=0.
- Backpressure and ignored input: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
  - diff, bout and out_valid stay stable; in_ready stays 0; the new operands are not taken.
  - After out_ready=1, the next operands are accepted one edge later.
- Reset mid-operation: assert rst during RUN (idx=2).
  - Outputs return immediately to reset values; no out_valid appears.
  - A fresh operation (a=0x00FF, b=0x0010) then yields diff=0x00EF, bout=0.
